// File: rtl/multilane_block_lock_timer_pkg.sv
// Shared definitions for the multilane block lock timer:
// lane state encoding, nominal window constants, counter width helper.
package multilane_block_lock_timer_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_LOCKED    = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } lane_state_e;

    localparam int SH_UNLOCKED_WIN = 64;
    localparam int SH_LOCKED_WIN   = 1024;
    localparam int SH_INVALID_LIM  = 65;

    function automatic int nb_cnt(input int max_window);
        return $clog2(max_window + 1);
    endfunction

endpackage

// File: rtl/multilane_block_lock_timer_if.sv
// Per-lane header stream in, lock/slip status out.
// master: header checker side; slave: lock timer side.
interface multilane_block_lock_timer_if #(
    parameter int N_LANES = 20
);
    logic [N_LANES-1:0] i_valid;
    logic [N_LANES-1:0] i_sh_valid;
    logic [N_LANES-1:0] i_lane_reset;
    logic [N_LANES-1:0] o_block_lock;
    logic [N_LANES-1:0] o_slip;
    logic               o_all_locked;

    modport master (
        output i_valid, i_sh_valid, i_lane_reset,
        input  o_block_lock, o_slip, o_all_locked
    );

    modport slave (
        input  i_valid, i_sh_valid, i_lane_reset,
        output o_block_lock, o_slip, o_all_locked
    );
endinterface

// File: rtl/multilane_block_lock_timer_block_lock_lane.sv
// Single-lane sync-header lock/slip FSM with window and invalid counters.
// Ports: i_event (enabled block), i_sh_valid, i_lane_reset, limits; o_block_lock, o_slip.
module block_lock_lane
    import multilane_block_lock_timer_pkg::*;
#(
    parameter int NB_CNT    = 12,
    parameter int SLIP_WAIT = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_event,
    input  logic              i_sh_valid,
    input  logic              i_lane_reset,
    input  logic [NB_CNT-1:0] i_unlocked_window,
    input  logic [NB_CNT-1:0] i_locked_window,
    input  logic [NB_CNT-1:0] i_invalid_limit,
    output logic              o_block_lock,
    output logic              o_slip
);

    localparam logic [NB_CNT-1:0] ONE  = NB_CNT'(1);
    localparam logic [NB_CNT-1:0] WAIT = NB_CNT'(SLIP_WAIT);

    // With no settle time the slip goes straight back to hunting.
    localparam lane_state_e AFTER_SLIP =
        (SLIP_WAIT == 0) ? ST_UNLOCKED : ST_SLIP_WAIT;

    lane_state_e       state_q, state_d;
    logic [NB_CNT-1:0] sh_cnt_q, sh_cnt_d;
    logic [NB_CNT-1:0] invld_cnt_q, invld_cnt_d;
    logic              lock_q, lock_d;
    logic              slip_q, slip_d;

    logic [NB_CNT-1:0] unl_win;
    logic [NB_CNT-1:0] lck_win;
    logic [NB_CNT-1:0] inv_lim;
    logic [NB_CNT-1:0] sh_inc;
    logic [NB_CNT-1:0] invld_inc;

    // A limit of zero behaves as one so a match is always reachable.
    assign unl_win   = (i_unlocked_window == '0) ? ONE : i_unlocked_window;
    assign lck_win   = (i_locked_window == '0) ? ONE : i_locked_window;
    assign inv_lim   = (i_invalid_limit == '0) ? ONE : i_invalid_limit;
    assign sh_inc    = sh_cnt_q + ONE;
    assign invld_inc = invld_cnt_q + ONE;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_UNLOCKED;
            sh_cnt_q    <= '0;
            invld_cnt_q <= '0;
            lock_q      <= 1'b0;
            slip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_cnt_q    <= sh_cnt_d;
            invld_cnt_q <= invld_cnt_d;
            lock_q      <= lock_d;
            slip_q      <= slip_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_cnt_d    = sh_cnt_q;
        invld_cnt_d = invld_cnt_q;
        lock_d      = lock_q;
        slip_d      = 1'b0;
        if (i_lane_reset) begin
            state_d     = ST_UNLOCKED;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
            lock_d      = 1'b0;
        end else if (i_event) begin
            unique case (state_q)
                ST_UNLOCKED: begin
                    if (!i_sh_valid) begin
                        slip_d      = 1'b1;
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                        state_d     = AFTER_SLIP;
                    end else if (sh_inc == unl_win) begin
                        lock_d      = 1'b1;
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                        state_d     = ST_LOCKED;
                    end else begin
                        sh_cnt_d = sh_inc;
                    end
                end
                ST_LOCKED: begin
                    // Unlock is checked first so it beats a window clear.
                    if (!i_sh_valid && invld_inc == inv_lim) begin
                        lock_d      = 1'b0;
                        slip_d      = 1'b1;
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                        state_d     = AFTER_SLIP;
                    end else if (sh_inc == lck_win) begin
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_inc;
                        if (!i_sh_valid) begin
                            invld_cnt_d = invld_inc;
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    if (sh_inc == WAIT) begin
                        sh_cnt_d = '0;
                        state_d  = ST_UNLOCKED;
                    end else begin
                        sh_cnt_d = sh_inc;
                    end
                end
                default: begin
                    state_d     = ST_UNLOCKED;
                    sh_cnt_d    = '0;
                    invld_cnt_d = '0;
                    lock_d      = 1'b0;
                end
            endcase
        end
    end

    assign o_block_lock = lock_q;
    assign o_slip       = slip_q;

endmodule

// File: rtl/multilane_block_lock_timer.sv
// N_LANES independent block lock machines plus a registered all-locked flag.
// Ports: i_clock, i_reset (async low), i_enable, limits; bus carries lane I/O.
module multilane_block_lock_timer
    import multilane_block_lock_timer_pkg::*;
#(
    parameter int N_LANES    = 20,
    parameter int MAX_WINDOW = 2048,
    parameter int SLIP_WAIT  = 4,
    parameter int NB_CNT     = nb_cnt(MAX_WINDOW)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [NB_CNT-1:0] i_unlocked_window,
    input  logic [NB_CNT-1:0] i_locked_window,
    input  logic [NB_CNT-1:0] i_invalid_limit,
    multilane_block_lock_timer_if.slave bus
);

    logic [N_LANES-1:0] lock;
    logic [N_LANES-1:0] slip;
    logic               all_locked_q, all_locked_d;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        block_lock_lane #(
            .NB_CNT    (NB_CNT),
            .SLIP_WAIT (SLIP_WAIT)
        ) u_lane (
            .i_clock           (i_clock),
            .i_reset           (i_reset),
            .i_event           (i_enable & bus.i_valid[k]),
            .i_sh_valid        (bus.i_sh_valid[k]),
            .i_lane_reset      (bus.i_lane_reset[k]),
            .i_unlocked_window (i_unlocked_window),
            .i_locked_window   (i_locked_window),
            .i_invalid_limit   (i_invalid_limit),
            .o_block_lock      (lock[k]),
            .o_slip            (slip[k])
        );
    end

    always_comb begin
        all_locked_d = &lock;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            all_locked_q <= 1'b0;
        end else begin
            all_locked_q <= all_locked_d;
        end
    end

    assign bus.o_block_lock = lock;
    assign bus.o_slip       = slip;
    assign bus.o_all_locked = all_locked_q;

endmodule

// File: tb/tb_multilane_block_lock_timer.sv
// Directed bench for multilane_block_lock_timer.
// Lock, slip/settle, window clear, unlock priority, enable, resets.
module tb_multilane_block_lock_timer;

    localparam int N  = 20;
    localparam int NB = 12;

    localparam logic [N-1:0] ALL = '1;
    localparam logic [N-1:0] Z   = '0;
    localparam logic [N-1:0] L0  = N'(1);
    localparam logic [N-1:0] L1  = N'(1) << 1;
    localparam logic [N-1:0] L2  = N'(1) << 2;
    localparam logic [N-1:0] L4  = N'(1) << 4;
    localparam logic [N-1:0] L5  = N'(1) << 5;
    localparam logic [N-1:0] L7  = N'(1) << 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic [NB-1:0] uw = NB'(64);
    logic [NB-1:0] lw = NB'(1024);
    logic [NB-1:0] il = NB'(65);

    int total = 0;
    int bad   = 0;

    multilane_block_lock_timer_if #(.N_LANES(N)) bus ();

    multilane_block_lock_timer #(
        .N_LANES    (N),
        .MAX_WINDOW (2048),
        .SLIP_WAIT  (4)
    ) dut (
        .i_clock           (clk),
        .i_reset           (rst_n),
        .i_enable          (en),
        .i_unlocked_window (uw),
        .i_locked_window   (lw),
        .i_invalid_limit   (il),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic blk(input int n, input logic [N-1:0] v,
                       input logic [N-1:0] sh);
        repeat (n) begin
            bus.i_valid    = v;
            bus.i_sh_valid = sh;
            step();
        end
        bus.i_valid    = '0;
        bus.i_sh_valid = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_valid      = '0;
        bus.i_sh_valid   = '0;
        bus.i_lane_reset = '0;
        step();
        step();
        chk("rst_lock", bus.o_block_lock, Z);
        chk("rst_slip", bus.o_slip, Z);
        chk("rst_all", N'(bus.o_all_locked), Z);
        rst_n = 1'b1;
        step();

        blk(63, L0, L0);
        chk("t1_63", bus.o_block_lock, Z);
        blk(1, L0, L0);
        chk("t1_64", bus.o_block_lock, L0);

        blk(10, L1, L1);
        blk(1, L1, Z);
        chk("t2_slip", bus.o_slip, L1);
        chk("t2_lock", bus.o_block_lock, L0);
        step();
        chk("t2_slip_off", bus.o_slip, Z);
        blk(4, L1, Z);
        chk("t2_wait", bus.o_slip, Z);
        blk(63, L1, L1);
        chk("t2_63", bus.o_block_lock, L0);
        blk(1, L1, L1);
        chk("t2_64", bus.o_block_lock, L0 | L1);

        blk(64, L0, Z);
        blk(960, L0, L0);
        chk("t3_win", bus.o_block_lock, L0 | L1);
        chk("t3_noslip", bus.o_slip, Z);
        blk(1, L0, Z);
        chk("t3_clr", bus.o_block_lock, L0 | L1);
        blk(63, L0, Z);
        chk("t3_64bad", bus.o_block_lock, L0 | L1);
        blk(1, L0, Z);
        chk("t3_unlock", bus.o_block_lock, L1);
        chk("t3_slip", bus.o_slip, L0);

        blk(64, L2, L2);
        chk("t4_lock", bus.o_block_lock, L1 | L2);
        blk(959, L2, L2);
        blk(64, L2, Z);
        chk("t4_1023", bus.o_block_lock, L1 | L2);
        blk(1, L2, Z);
        chk("t4_unlock", bus.o_block_lock, L1);
        chk("t4_slip", bus.o_slip, L2);

        blk(4, L0, L0);
        blk(63, L0, L0);
        chk("sw_63", bus.o_block_lock, L1);
        blk(1, L0, L0);
        chk("sw_64", bus.o_block_lock, L0 | L1);

        bus.i_lane_reset = ALL;
        step();
        bus.i_lane_reset = '0;
        chk("t5_lrst", bus.o_block_lock, Z);
        blk(64, ALL, ALL);
        chk("t5_lock", bus.o_block_lock, ALL);
        chk("t5_all_lag", N'(bus.o_all_locked), Z);
        step();
        chk("t5_all", N'(bus.o_all_locked), N'(1));
        bus.i_lane_reset = L7;
        step();
        bus.i_lane_reset = '0;
        chk("t5_l7", bus.o_block_lock, ~L7);
        chk("t5_all_hold", N'(bus.o_all_locked), N'(1));
        step();
        chk("t5_all_drop", N'(bus.o_all_locked), Z);
        en = 1'b0;
        blk(70, ALL, Z);
        chk("t5_en_lock", bus.o_block_lock, ~L7);
        chk("t5_en_slip", bus.o_slip, Z);
        en = 1'b1;
        blk(64, L7, L7);
        chk("t5_relock", bus.o_block_lock, ALL);
        step();
        chk("t5_all2", N'(bus.o_all_locked), N'(1));

        bus.i_lane_reset = L4;
        step();
        bus.i_lane_reset = '0;
        blk(1, L4, Z);
        chk("t6_slip", bus.o_slip, L4);
        blk(2, L4, L4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_lock", bus.o_block_lock, Z);
        chk("t6_slip0", bus.o_slip, Z);
        chk("t6_all", N'(bus.o_all_locked), Z);
        step();
        rst_n = 1'b1;
        blk(63, ALL, ALL);
        chk("t6_63", bus.o_block_lock, Z);
        blk(1, ALL, ALL);
        chk("t6_64", bus.o_block_lock, ALL);

        bus.i_lane_reset = L5;
        step();
        bus.i_lane_reset = '0;
        chk("z_lrst", bus.o_block_lock, ~L5);
        uw = '0;
        blk(1, L5, L5);
        chk("z_uw", bus.o_block_lock, ALL);
        il = '0;
        blk(1, L5, Z);
        chk("z_il_lock", bus.o_block_lock, ~L5);
        chk("z_il_slip", bus.o_slip, L5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
